axi_aw_arbiter: RTL and testbench
=================================

Name: axi_aw_arbiter

Overview:
- Shares ip1's single AXI write port (AW plus W channels) between NUM_REQ requesters inside fpga_top.
- Grants are round-robin. A grant is held from AW handshake through the W beat carrying WLAST, so write data is never interleaved.
- The granted requester's index is tagged onto the upstream AWID.
- The arbiter checks WLAST against the AWLEN of the granted burst.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 4, requester-side AWID width
- LEN_W, 8, AWLEN width
- ADDR_W, 32, AWADDR width
- DATA_W, 64, WDATA width; WSTRB width is DATA_W/8
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_awvalid  in  NUM_REQ  per-requester AW valid
- s_awready  out  NUM_REQ  per-requester AW ready
- s_awid  in  NUM_REQ*ID_W  flattened; requester r in slice r
- s_awaddr  in  NUM_REQ*ADDR_W  flattened
- s_awlen  in  NUM_REQ*LEN_W  flattened
- s_wvalid  in  NUM_REQ  per-requester W valid
- s_wready  out  NUM_REQ  per-requester W ready
- s_wdata  in  NUM_REQ*DATA_W  flattened
- s_wstrb  in  NUM_REQ*DATA_W/8  flattened
- s_wlast  in  NUM_REQ  per-requester W last
- m_awvalid  out  1  to ip1 axi_awvalid
- m_awready  in  1  from ip1
- m_awid  out  IDX_W+ID_W  {grant index, s_awid of granted requester}
- m_awaddr  out  ADDR_W
- m_awlen  out  LEN_W
- m_wvalid  out  1
- m_wready  in  1
- m_wdata  out  DATA_W
- m_wstrb  out  DATA_W/8
- m_wlast  out  1
- err_wlast  out  1  one-cycle pulse on a WLAST/AWLEN mismatch

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_awvalid is set, pick the first set bit at or after rr_ptr, scanning upward with wrap NUM_REQ-1 -> 0.
  - Register the winner in gnt_idx and go to ADDR.
  - No arbitration happens in ADDR or DATA.
- ADDR:
  - m_awvalid=1; m_aw* are muxed from requester gnt_idx.
  - s_awready[gnt_idx]=m_awready; all other s_awready bits are 0.
  - On m_awvalid & m_awready: capture the AWLEN value into len_q, clear beat_cnt, go to DATA.
  - Latency: m_awvalid rises 1 cycle after s_awvalid is first seen in IDLE.
- DATA:
  - m_w* are muxed from gnt_idx; s_wready[gnt_idx]=m_wready; all other s_wready bits are 0.
  - beat_cnt increments on each m_wvalid & m_wready.
  - Completion beat: a handshake where s_wlast=1 or beat_cnt==len_q. On it:
    - set rr_ptr = gnt_idx+1, wrapping NUM_REQ -> 0;
    - return to IDLE.
  - The next grant is issued in IDLE, so there is one dead cycle between bursts.
- WLAST check (evaluated only on the completion beat):
  - s_wlast=1 with beat_cnt!=len_q: early WLAST.
  - beat_cnt==len_q with s_wlast=0: missing WLAST.
  - Either case pulses err_wlast for 1 cycle, and the burst is still treated as complete.
  - m_wlast is forced to 1 on the completion beat, so ip1 always sees exactly len_q+1 beats.
- AWLEN=0 means a single beat.
- Unselected requester W beats get wready=0; a requester may present W before its AW is granted.
- Dropping s_awvalid in ADDR before the handshake is a requester protocol violation; the result is undefined and not checked.
- Reset (also when asserted mid-burst):
  - state=IDLE, rr_ptr=0, gnt_idx=0, len_q=0, beat_cnt=0;
  - all outputs 0: m_awvalid, m_wvalid, s_awready, s_wready, err_wlast;
  - m_w* and m_aw* payloads read as 0 because their selects are gated by state.
- beat_cnt is LEN_W+1 bits wide and cannot overflow.

Optional Feature:
- Macro: AXI_AW_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt (NUM_REQ*16, flattened): one 16-bit saturating counter per requester, incremented on that requester's AW handshake.
  - Adds output port err_cnt (16): a saturating count of err_wlast pulses.
  - All counters reset to 0.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package axi_arb_pkg holds:
  - the state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2);
  - the STATS_W=16 constant;
  - the function that computes the index width.
- One sub-module, rr_pick: combinational round-robin select (req vector plus rr_ptr in, index and found out).
- Everything else stays in axi_aw_arbiter.

Test Plan:
- Single burst: req1 raises AW with awlen=3, awid=4'h5; m_awready=1 → m_awvalid one cycle later, m_awid={2'd1,4'h5}; 4 W beats pass through; beat 4 has m_wlast=1; err_wlast stays 0.
- Fairness: all 4 requesters hold AW with awlen=0 continuously → grant order 0,1,2,3,0, each burst separated by one IDLE cycle.
- Backpressure: m_awready low for 5 cycles, then m_wready toggled every cycle during an awlen=7 burst → no beat lost or duplicated; other requesters see s_awready=0 and s_wready=0 throughout.
- Early WLAST: awlen=3 with s_wlast set on beat 2 → one err_wlast pulse, FSM back to IDLE, next requester granted.
- Missing WLAST: awlen=1, s_wlast never set → m_wlast=1 on beat 2, err_wlast pulse. With AXI_AW_ARB_STATS_EN defined, err_cnt=1.
- Reset mid-burst: rst_n low during beat 2 of 4 → all outputs 0 immediately; after release, req0 wins first, confirming rr_ptr=0.

Source files
------------

// File: rtl/axi_aw_arbiter_pkg.sv
// Shared types and constants for the AXI AW/W write-port arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int unsigned STATS_W = 16;

  // Index width for a requester count; a lone requester still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_aw_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr,
// scanning upward and wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_aw_arbiter.sv
// Round-robin arbiter sharing one AXI write port (AW + W) between NUM_REQ
// requesters. A grant is held from the AW handshake through the completing
// W beat, so bursts never interleave. The grant index is prepended to AWID,
// and WLAST is cross-checked against the captured AWLEN.
// Optional per-requester grant counters and an error counter are built when
// AXI_AW_ARB_STATS_EN is defined.
module axi_aw_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned ID_W    = 4,
  parameter  int unsigned LEN_W   = 8,
  parameter  int unsigned ADDR_W  = 32,
  parameter  int unsigned DATA_W  = 64,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ),
  localparam int unsigned STRB_W  = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          s_awvalid,
  output logic [NUM_REQ-1:0]          s_awready,
  input  logic [NUM_REQ*ID_W-1:0]     s_awid,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_REQ*LEN_W-1:0]    s_awlen,
  input  logic [NUM_REQ-1:0]          s_wvalid,
  output logic [NUM_REQ-1:0]          s_wready,
  input  logic [NUM_REQ*DATA_W-1:0]   s_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]   s_wstrb,
  input  logic [NUM_REQ-1:0]          s_wlast,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [IDX_W+ID_W-1:0]       m_awid,
  output logic [ADDR_W-1:0]           m_awaddr,
  output logic [LEN_W-1:0]            m_awlen,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  output logic [DATA_W-1:0]           m_wdata,
  output logic [STRB_W-1:0]           m_wstrb,
  output logic                        m_wlast,
  output logic                        err_wlast
`ifdef AXI_AW_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0]  grant_cnt,
  output logic [STATS_W-1:0]          err_cnt
`endif
);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W:0]     beat_cnt;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  logic [ID_W-1:0]    awid_a   [NUM_REQ];
  logic [ADDR_W-1:0]  awaddr_a [NUM_REQ];
  logic [LEN_W-1:0]   awlen_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a  [NUM_REQ];
  logic [STRB_W-1:0]  wstrb_a  [NUM_REQ];

  logic in_addr, in_data, aw_hs, w_hs, len_hit, done_beat;

  // Split the flattened requester buses into per-requester views.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      awid_a[r]   = s_awid[r*ID_W +: ID_W];
      awaddr_a[r] = s_awaddr[r*ADDR_W +: ADDR_W];
      awlen_a[r]  = s_awlen[r*LEN_W +: LEN_W];
      wdata_a[r]  = s_wdata[r*DATA_W +: DATA_W];
      wstrb_a[r]  = s_wstrb[r*STRB_W +: STRB_W];
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (s_awvalid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Handshake and completion qualifiers for the granted requester.
  always_comb begin
    in_addr   = (state == ADDR);
    in_data   = (state == DATA);
    aw_hs     = in_addr & m_awready;
    w_hs      = in_data & s_wvalid[gnt_idx] & m_wready;
    len_hit   = (beat_cnt == {1'b0, len_q});
    done_beat = w_hs & (s_wlast[gnt_idx] | len_hit);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and port muxing; payloads are gated to zero outside their phase.
  always_comb begin
    state_nxt = state;
    m_awvalid = 1'b0;
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    err_wlast = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = ADDR;
      end
      ADDR: begin
        m_awvalid          = 1'b1;
        m_awid             = {gnt_idx, awid_a[gnt_idx]};
        m_awaddr           = awaddr_a[gnt_idx];
        m_awlen            = awlen_a[gnt_idx];
        s_awready[gnt_idx] = m_awready;
        if (m_awready) state_nxt = DATA;
      end
      DATA: begin
        m_wvalid          = s_wvalid[gnt_idx];
        m_wdata           = wdata_a[gnt_idx];
        m_wstrb           = wstrb_a[gnt_idx];
        // Forcing WLAST at the AWLEN count keeps ip1's beat count exact.
        m_wlast           = s_wlast[gnt_idx] | len_hit;
        s_wready[gnt_idx] = m_wready;
        err_wlast         = done_beat & (s_wlast[gnt_idx] ^ len_hit);
        if (done_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, round-robin pointer, burst length and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == IDLE && pick_found) gnt_idx <= pick_idx;
      if (aw_hs) begin
        len_q    <= awlen_a[gnt_idx];
        beat_cnt <= '0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (done_beat)
        rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

`ifdef AXI_AW_ARB_STATS_EN
  logic [STATS_W-1:0] gcnt [NUM_REQ];

  // Saturating per-requester AW grant counters and WLAST error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) gcnt[r] <= '0;
      err_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REQ; r++)
        if (aw_hs && gnt_idx == IDX_W'(r) && gcnt[r] != '1)
          gcnt[r] <= gcnt[r] + 1'b1;
      if (err_wlast && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++)
      grant_cnt[r*STATS_W +: STATS_W] = gcnt[r];
  end
`endif

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// Randomized bench for axi_aw_arbiter with a transaction-level reference model.
module tb_axi_aw_arbiter;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int LW = 8;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int XW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [N*IW-1:0]   s_awid;
  logic [N*AW-1:0]   s_awaddr;
  logic [N*LW-1:0]   s_awlen;
  logic [N*DW-1:0]   s_wdata;
  logic [N*SW-1:0]   s_wstrb;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, err_wlast;
  logic [XW+IW-1:0]  m_awid;
  logic [AW-1:0]     m_awaddr;
  logic [LW-1:0]     m_awlen;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;
`ifdef AXI_AW_ARB_STATS_EN
  logic [N*16-1:0]   grant_cnt;
  logic [15:0]       err_cnt;
`endif

  always #5 clk = ~clk;

  axi_aw_arbiter #(
    .NUM_REQ (N),
    .ID_W    (IW),
    .LEN_W   (LW),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awid    (s_awid),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awid    (m_awid),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .err_wlast (err_wlast)
`ifdef AXI_AW_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester behaviour: one outstanding burst each.
  // mode 0 = WLAST on the AWLEN beat, 1 = early WLAST, 2 = WLAST never set.
  bit            has [N];
  bit            awd [N];
  bit            wv  [N];
  int            blen[N];
  int            mode[N];
  int            early[N];
  int            wi  [N];
  logic [IW-1:0] bid [N];
  logic [AW-1:0] baddr[N];
  logic [DW-1:0] bdata[N];
  logic [SW-1:0] bstrb[N];
  bit            awhs[N];
  bit            whs [N];

  int p_aw, p_w, p_awr, p_wr, max_len;
  bit len0, err_modes;

  // Reference model: who holds the port, what burst, which beat.
  bit mbusy, mawd;
  int mg, mptr, mlen, mbeat;
  int mgrant[N];
  int merr;
  int gq[$];

  function automatic bit cur_last(input int r);
    case (mode[r])
      0:       return wi[r] == blen[r];
      1:       return wi[r] == early[r];
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      s_awvalid[r]            = has[r] && !awd[r];
      s_awid[r*IW +: IW]      = bid[r];
      s_awaddr[r*AW +: AW]    = baddr[r];
      s_awlen[r*LW +: LW]     = LW'(blen[r]);
      s_wvalid[r]             = has[r] && wv[r];
      s_wdata[r*DW +: DW]     = bdata[r];
      s_wstrb[r*SW +: SW]     = bstrb[r];
      s_wlast[r]              = has[r] && cur_last(r);
    end
  endtask

  task automatic new_burst(input int r);
    int m;
    has[r]   = 1'b1;
    awd[r]   = 1'b0;
    wi[r]    = 0;
    blen[r]  = len0 ? 0 : $urandom_range(max_len);
    bid[r]   = IW'($urandom);
    baddr[r] = $urandom;
    bdata[r] = {$urandom, $urandom};
    bstrb[r] = SW'($urandom);
    mode[r]  = 0;
    early[r] = 0;
    if (err_modes) begin
      m = $urandom_range(9);
      if (m >= 7 && m <= 8 && blen[r] >= 1) begin
        mode[r]  = 1;
        early[r] = $urandom_range(blen[r] - 1);
      end else if (m == 9) begin
        mode[r] = 2;
      end
    end
  endtask

  // Compare DUT outputs with the model for this cycle, then advance the model.
  task automatic step();
    logic [N-1:0] exp_awr, exp_wr;
    bit aw_ph, w_ph, hs, last_exp, comp, e;
    aw_ph    = mbusy && !mawd;
    w_ph     = mbusy && mawd;
    hs       = w_ph && s_wvalid[mg] && m_wready;
    last_exp = s_wlast[mg] || (mbeat == mlen);
    comp     = hs && last_exp;
    e        = comp && (s_wlast[mg] != (mbeat == mlen));
    exp_awr  = '0;
    exp_wr   = '0;
    if (aw_ph && m_awready) exp_awr[mg] = 1'b1;
    if (w_ph && m_wready)   exp_wr[mg]  = 1'b1;

    check("m_awvalid", m_awvalid, aw_ph);
    check("s_awready", s_awready, exp_awr);
    check("s_wready",  s_wready,  exp_wr);
    check("m_wvalid",  m_wvalid,  w_ph && s_wvalid[mg]);
    check("err_wlast", err_wlast, e);
    if (aw_ph) begin
      check("m_awid",   m_awid,   {mg[1:0], bid[mg]});
      check("m_awaddr", m_awaddr, baddr[mg]);
      check("m_awlen",  m_awlen,  blen[mg]);
    end else begin
      check("m_aw_gated", {m_awid, m_awaddr, m_awlen}, 0);
    end
    if (w_ph && s_wvalid[mg]) begin
      check("m_wdata", m_wdata, bdata[mg]);
      check("m_wstrb", m_wstrb, bstrb[mg]);
      check("m_wlast", m_wlast, last_exp);
    end else if (!w_ph) begin
      check("m_w_gated", {m_wlast, m_wstrb, (|m_wdata)}, 0);
    end

    for (int r = 0; r < N; r++) begin
      awhs[r] = s_awvalid[r] && s_awready[r];
      whs[r]  = s_wvalid[r] && s_wready[r];
    end

    if (!mbusy) begin
      for (int k = 0; k < N; k++) begin
        if (!mbusy && s_awvalid[(mptr + k) % N]) begin
          mg    = (mptr + k) % N;
          mbusy = 1'b1;
          mawd  = 1'b0;
        end
      end
    end else if (aw_ph) begin
      if (m_awready) begin
        mawd  = 1'b1;
        mlen  = blen[mg];
        mbeat = 0;
        if (mgrant[mg] < 65535) mgrant[mg]++;
        gq.push_back(mg);
      end
    end else if (hs) begin
      if (comp) begin
        mbusy = 1'b0;
        mptr  = (mg + 1) % N;
        if (e && merr < 65535) merr++;
      end else begin
        mbeat++;
      end
    end
  endtask

  // Requesters react to the handshakes of the edge just passed.
  task automatic bfm_update();
    for (int r = 0; r < N; r++) begin
      if (awhs[r]) awd[r] = 1'b1;
      if (whs[r]) begin
        if (cur_last(r) || wi[r] == blen[r]) begin
          has[r] = 1'b0;
        end else begin
          wi[r]++;
          bdata[r] = {$urandom, $urandom};
          bstrb[r] = SW'($urandom);
        end
      end
      if (!has[r] && $urandom_range(99) < p_aw) new_burst(r);
      wv[r] = $urandom_range(99) < p_w;
    end
    m_awready = $urandom_range(99) < p_awr;
    m_wready  = $urandom_range(99) < p_wr;
    drive();
  endtask

  task automatic cyc();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
    bfm_update();
  endtask

  task automatic stats_check(input string tag);
`ifdef AXI_AW_ARB_STATS_EN
    logic [15:0] g;
    for (int r = 0; r < N; r++) begin
      g = grant_cnt[r*16 +: 16];
      check({tag, "_grant_cnt"}, g, mgrant[r]);
    end
    check({tag, "_err_cnt"}, err_cnt, merr);
`else
    checks = checks + 0;
`endif
  endtask

  // Assert reset asynchronously, confirm outputs clear at once, then restart.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valids", {m_awvalid, m_wvalid, err_wlast, s_awready, s_wready}, 0);
    check("rst_aw_payload", {m_awid, m_awaddr, m_awlen}, 0);
    check("rst_w_payload", {m_wlast, m_wstrb, (|m_wdata)}, 0);
    for (int r = 0; r < N; r++) begin
      has[r] = 0; awd[r] = 0; wv[r] = 0; wi[r] = 0; blen[r] = 0; mode[r] = 0;
      early[r] = 0; bid[r] = '0; baddr[r] = '0; bdata[r] = '0; bstrb[r] = '0;
      awhs[r] = 0; whs[r] = 0; mgrant[r] = 0;
    end
    mbusy = 0; mawd = 0; mg = 0; mptr = 0; mlen = 0; mbeat = 0; merr = 0;
    gq.delete();
    m_awready = 1'b0;
    m_wready  = 1'b0;
    drive();
    stats_check("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    rst_n     = 1'b1;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    p_aw = 0; p_w = 0; p_awr = 0; p_wr = 0; max_len = 7; len0 = 0; err_modes = 0;
    for (int r = 0; r < N; r++) begin
      has[r] = 0; awd[r] = 0; wv[r] = 0; wi[r] = 0; blen[r] = 0; mode[r] = 0;
      early[r] = 0; bid[r] = '0; baddr[r] = '0; bdata[r] = '0; bstrb[r] = '0;
    end
    drive();
    #2;
    do_reset();

    // Single burst from requester 1: awlen=3, awid=5, everything ready.
    p_aw = 0; p_w = 100; p_awr = 100; p_wr = 100;
    new_burst(1);
    blen[1] = 3; bid[1] = 4'h5; mode[1] = 0;
    wv[1] = 1'b1;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    drive();
    repeat (10) cyc();
    check("single_grant_idx", (gq.size() > 0) ? gq[0] : 99, 1);
    check("single_done", has[1], 0);
    stats_check("single");

    // Fairness: everyone requests single-beat bursts continuously.
    do_reset();
    p_aw = 100; p_w = 100; p_awr = 100; p_wr = 100; len0 = 1; err_modes = 0;
    repeat (24) cyc();
    for (int k = 0; k < 5; k++)
      check($sformatf("fair_order%0d", k), (gq.size() > k) ? gq[k] : 99, k % N);
    stats_check("fair");

    // Random traffic with WLAST errors mixed in.
    do_reset();
    len0 = 0; err_modes = 1; max_len = 7;
    p_aw = 60; p_w = 70; p_awr = 60; p_wr = 60;
    repeat (3000) cyc();
    stats_check("rand");

    // Heavy backpressure on both master channels.
    p_awr = 15; p_wr = 50; p_w = 60;
    repeat (1500) cyc();
    stats_check("bp");

    // Reset in the middle of a data burst; the next grant must go to 0.
    p_aw = 100; p_w = 100; p_awr = 100; p_wr = 100; err_modes = 0;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      cyc();
      if (mbusy && mawd && mbeat >= 1) hit = 1;
    end
    check("midburst_reached", hit, 1);
    do_reset();
    for (int i = 0; i < 50 && gq.size() == 0; i++) cyc();
    check("post_reset_first", (gq.size() > 0) ? gq[0] : 99, 0);
    repeat (40) cyc();
    stats_check("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
